// File: rtl/game_disp_pkg.sv
// Shared types and constants for the game time display.
// Holds the conversion FSM state enum, the BCD digit struct, display constants
// and the per-cycle add-3 adjustment used by the double-dabble converter.
package game_disp_pkg;

  localparam int unsigned CNT_W    = 10;  // tenths count width
  localparam int unsigned BCD_W    = 16;  // four packed BCD digits
  localparam int unsigned ITER_W   = 4;   // shift iteration counter width
  localparam int unsigned N_DIGITS = 4;
  localparam int unsigned SCAN_W   = 2;   // index over N_DIGITS
  localparam int unsigned DP_DIGIT = 1;   // digit carrying the decimal point

  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(CNT_W - 1);

  // Active-low {dp,g,f,e,d,c,b,a}; all segments dark.
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [6:0] SEG7_OFF  = SEG_BLANK[6:0];

  // Active-low {g,f,e,d,c,b,a} glyphs for 0-9.
  localparam logic [6:0] SEG7_0 = 7'h40;
  localparam logic [6:0] SEG7_1 = 7'h79;
  localparam logic [6:0] SEG7_2 = 7'h24;
  localparam logic [6:0] SEG7_3 = 7'h30;
  localparam logic [6:0] SEG7_4 = 7'h19;
  localparam logic [6:0] SEG7_5 = 7'h12;
  localparam logic [6:0] SEG7_6 = 7'h02;
  localparam logic [6:0] SEG7_7 = 7'h78;
  localparam logic [6:0] SEG7_8 = 7'h00;
  localparam logic [6:0] SEG7_9 = 7'h10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_e;

  // d3 hundreds, d2 tens, d1 units, d0 tenths.
  typedef struct packed {
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
  } bcd_digits_t;

  // Double-dabble correction: any nibble >= 5 gets +3 before the next shift.
  function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] acc);
    logic [BCD_W-1:0] res;
    res = acc;
    for (int i = 0; i < 4; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-low 7-segment decoder.
// Ports: bcd (digit 0-9), blank (force dark), seg_n_c ({g,f,e,d,c,b,a}, active low).
// Codes 10-15 decode to dark.
module bcd_to_seg7
  import game_disp_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg_n_c
);

  always_comb begin
    seg_n_c = SEG7_OFF;
    if (!blank) begin
      case (bcd)
        4'd0:    seg_n_c = SEG7_0;
        4'd1:    seg_n_c = SEG7_1;
        4'd2:    seg_n_c = SEG7_2;
        4'd3:    seg_n_c = SEG7_3;
        4'd4:    seg_n_c = SEG7_4;
        4'd5:    seg_n_c = SEG7_5;
        4'd6:    seg_n_c = SEG7_6;
        4'd7:    seg_n_c = SEG7_7;
        4'd8:    seg_n_c = SEG7_8;
        4'd9:    seg_n_c = SEG7_9;
        default: seg_n_c = SEG7_OFF;
      endcase
    end
  end

endmodule

// File: rtl/game_time_display.sv
// Game time display: converts the tenths-of-a-second count to BCD with a
// sequential double-dabble engine and scans it onto a 4-digit 7-segment
// display as SSS.T with optional leading-zero blanking.
// Ports:
//   CLOCK10M  system clock
//   RST_N     asynchronous active-low reset
//   count_in  tenths count 0-1023
//   bcd_out   {d3,d2,d1,d0} converted digits
//   update    one-cycle pulse when bcd_out takes a new value
//   busy      conversion in progress
//   seg_n     active-low {dp,g,f,e,d,c,b,a}
//   dig_n     active-low one-hot digit select, bit i = digit i
module game_time_display
  import game_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 10000,
  parameter bit          LEAD_BLANK = 1'b1
) (
  input  logic                CLOCK10M,
  input  logic                RST_N,
  input  logic [CNT_W-1:0]    count_in,
  output logic [BCD_W-1:0]    bcd_out,
  output logic                update,
  output logic                busy,
  output logic [7:0]          seg_n,
  output logic [N_DIGITS-1:0] dig_n
);

  localparam int unsigned     DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  // Conversion state
  conv_state_e       state_q, state_d;
  logic [CNT_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0]  sh_q, sh_d;
  logic [BCD_W-1:0]  acc_q, acc_d;
  logic [BCD_W-1:0]  acc_adj;
  logic [ITER_W-1:0] iter_q, iter_d;
  bcd_digits_t       bcd_q, bcd_d;
  logic              update_q, update_d;
  logic              busy_q, busy_d;

  // Display scan state
  logic [DIV_W-1:0]    div_q, div_d;
  logic [SCAN_W-1:0]   scan_q, scan_d;
  logic [7:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] dig_q, dig_d;

  logic [3:0] digit_sel;
  logic       blank_sel;
  logic       blank3, blank2;
  logic [6:0] seg7_c;

  // Conversion FSM state register
  always_ff @(posedge CLOCK10M or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      last_q   <= '0;
      sh_q     <= '0;
      acc_q    <= '0;
      iter_q   <= '0;
      bcd_q    <= '0;
      update_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      sh_q     <= sh_d;
      acc_q    <= acc_d;
      iter_q   <= iter_d;
      bcd_q    <= bcd_d;
      update_q <= update_d;
      busy_q   <= busy_d;
    end
  end

  // Conversion FSM next-state: change detect, shift-add-3, commit
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    sh_d     = sh_q;
    acc_d    = acc_q;
    iter_d   = iter_q;
    bcd_d    = bcd_q;
    update_d = 1'b0;
    acc_adj  = add3_nibbles(acc_q);

    case (state_q)
      IDLE: begin
        // Changes during SHIFT/COMMIT are picked up here on return.
        if (count_in != last_q) begin
          last_d  = count_in;
          sh_d    = count_in;
          acc_d   = '0;
          iter_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {acc_d, sh_d} = {acc_adj, sh_q} << 1;
        iter_d        = iter_q + ITER_W'(1);
        if (iter_q == LAST_ITER) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        bcd_d    = bcd_digits_t'(acc_q);
        update_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Scan divider and display output registers
  always_ff @(posedge CLOCK10M or negedge RST_N) begin
    if (!RST_N) begin
      div_q  <= '0;
      scan_q <= '0;
      seg_q  <= {1'b1, SEG7_0};
      dig_q  <= N_DIGITS'(4'b1110);
    end else begin
      div_q  <= div_d;
      scan_q <= scan_d;
      seg_q  <= seg_d;
      dig_q  <= dig_d;
    end
  end

  // Leading-zero blanking: d2 only blanks when d3 is already blank
  assign blank3 = LEAD_BLANK && (bcd_q.d3 == 4'd0);
  assign blank2 = blank3 && (bcd_q.d2 == 4'd0);

  // Digit and blank select for the current scan slot
  always_comb begin
    digit_sel = bcd_q.d0;
    blank_sel = 1'b0;
    case (scan_q)
      2'd0: digit_sel = bcd_q.d0;
      2'd1: digit_sel = bcd_q.d1;
      2'd2: begin
        digit_sel = bcd_q.d2;
        blank_sel = blank2;
      end
      2'd3: begin
        digit_sel = bcd_q.d3;
        blank_sel = blank3;
      end
      default: begin
        digit_sel = bcd_q.d0;
        blank_sel = 1'b0;
      end
    endcase
  end

  bcd_to_seg7 u_seg7 (
    .bcd     (digit_sel),
    .blank   (blank_sel),
    .seg_n_c (seg7_c)
  );

  // Scan divider next-state and registered segment/digit drive
  always_comb begin
    div_d  = div_q + DIV_W'(1);
    scan_d = scan_q;
    if (div_q == DIV_LAST) begin
      div_d  = '0;
      scan_d = scan_q + SCAN_W'(1);
    end
    // seg and dig both derive from scan_q so they update on the same edge.
    seg_d = {(scan_q != SCAN_W'(DP_DIGIT)), seg7_c};
    dig_d = ~(N_DIGITS'(1) << scan_q);
  end

  assign bcd_out = bcd_q;
  assign update  = update_q;
  assign busy    = busy_q;
  assign seg_n   = seg_q;
  assign dig_n   = dig_q;

endmodule
